regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Integer register file plus per-register pending-write scoreboard for the RVGA pipeline. The block consumes the write fields that the top level unpacks from the writeback stage's register-file control word. It serves two combinational read ports to decode, with same-cycle write-through bypass. It tracks in-flight writes per architectural register so decode can detect RAW hazards and stall.

## Interface
Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; index width AW = $clog2(NREG).
- CNT_W, 2, width of each pending counter; maximum in-flight writes per register PMAX = 2^CNT_W - 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wb_we  in  1  writeback write strobe; valid for exactly one cycle per retired write.
- wb_rd  in  AW  writeback destination register.
- wb_data  in  XLEN  writeback data.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  XLEN  read port 1 data, combinational.
- rs2_data  out  XLEN  read port 2 data, combinational.
- rs1_used  in  1  decode instruction reads rs1.
- rs2_used  in  1  decode instruction reads rs2.
- issue_valid  in  1  decode issues an instruction this cycle.
- issue_rd  in  AW  destination of the issuing instruction.
- issue_we  in  1  issuing instruction writes issue_rd.
- hazard  out  1  combinational; decode must not issue while high.
- sb_full  out  1  combinational; pending[issue_rd] is at PMAX and no release of it is in progress this cycle.
- flush  in  1  clears all pending counters; pipeline kill.
- sb_err  out  1  sticky protocol-error flag.

## Operation
- Storage is regs[0..NREG-1] of XLEN bits and pending[0..NREG-1] of CNT_W bits.
- Register 0 reads as 0 and ignores writes. Its pending counter is always 0 and it never contributes to hazard or sb_full.
- Write: at the clock edge with wb_we=1 and wb_rd≠0, regs[wb_rd] <= wb_data.
- Read, for each port: if addr=0, data=0. Else if wb_we=1 and wb_rd=addr, data=wb_data (bypass). Else data=regs[addr].
- Pending counter update, per register r≠0, with inc = issue_valid & issue_we & issue_rd=r and dec = wb_we & wb_rd=r:
  - inc only: +1. If the counter is already at PMAX it holds and sb_err is set.
  - dec only: -1. If the counter is already 0 it holds and sb_err is set.
  - inc and dec: unchanged.
- Hazard for source s ∈ {rs1, rs2}: s_used & s≠0 & eff(s)≠0. eff(s) = pending[s] - (dec on s this cycle ? 1 : 0).
  - A write completing this cycle resolves the hazard through the bypass.
  - hazard = OR over both sources. It does not depend on issue_valid.
- flush: at the clock edge all pending counters are set to 0. It overrides any inc/dec in the same cycle. regs are unaffected, and a write landing in the same cycle still updates regs.
- After flush, late writebacks to a counter at 0 set sb_err. The pipeline guarantees none occur.
- sb_err is cleared only by reset.

## Timing
- Reset, while rst_n=0 at an edge: all regs=0, all pending=0, sb_err=0.
  - Outputs during and after reset: rs1_data=rs2_data=0, hazard=0, sb_full=0.
  - Reset overrides wb_we, issue_valid and flush.
- Read latency: 0 cycles (combinational). Write-to-read through the array takes one edge; the same cycle is covered by the bypass.
- Issue-to-hazard: hazard on the issued rd is visible in the cycle after the issue edge.
- Writeback release: hazard drops in the same cycle wb_we is presented for the last pending write.
- Back-to-back issue and writeback to the same register on every cycle leave the counter stable.
- Reset mid-operation discards all pending state. No partial writes complete.

## Test plan
- Reset, then read all addresses -> rs1_data=rs2_data=0, hazard=0, sb_err=0.
- Issue rd=5, then wait 3 cycles with rs1_addr=5, rs1_used=1 -> hazard=1 for those 3 cycles. Then wb_we rd=5 data=0xDEADBEEF -> in the same cycle rs1_data=0xDEADBEEF and hazard=0. Next cycle regs[5]=0xDEADBEEF from the array.
- Write rd=0 data=0x1234 with issue rd=0 -> rs1_data for addr 0 stays 0, hazard stays 0, counter 0 unchanged.
- Issue rd=7 three times (CNT_W=2) -> sb_full=1 with issue_rd=7. A fourth issue -> counter holds at 3 and sb_err=1. Simultaneous issue and wb on rd=7 -> counter stays 3.
- Issue rd=3 and rd=9, then assert flush with wb_we rd=3 data=0x55 -> next cycle pending all 0, hazard=0, regs[3]=0x55, sb_err=0.
- wb_we to rd=12 with pending[12]=0 -> regs[12] written, sb_err=1 and still 1 after 10 idle cycles. Then rst_n=0 for one edge -> sb_err=0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-through bypass and a per-register pending-write
// scoreboard that flags RAW hazards to decode.
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            rs1_used,
  input  logic            rs2_used,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_we,
  output logic            hazard,
  output logic            sb_full,
  input  logic            flush,
  output logic            sb_err
);

  localparam logic [CNT_W-1:0] PMAX = '1;

  logic [XLEN-1:0]  regs    [NREG];
  logic [CNT_W-1:0] pending [NREG];
  logic [NREG-1:0]  inc_vec;
  logic [NREG-1:0]  dec_vec;
  logic             rs1_haz;
  logic             rs2_haz;

  // One-hot increment/decrement requests; register 0 never takes part.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    inc_vec = '0;
    dec_vec = '0;
    if (issue_valid && issue_we) inc_vec[issue_rd] = 1'b1;
    if (wb_we)                   dec_vec[wb_rd]    = 1'b1;
    inc_vec[0] = 1'b0;
    dec_vec[0] = 1'b0;
  end

  // Read ports with same-cycle bypass; all outputs held at 0 while in reset.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rst_n && rs1_addr != '0)
      rs1_data = (wb_we && wb_rd == rs1_addr) ? wb_data : regs[rs1_addr];
    if (rst_n && rs2_addr != '0)
      rs2_data = (wb_we && wb_rd == rs2_addr) ? wb_data : regs[rs2_addr];
  end

  // A write completing this cycle consumes one pending count before the compare.
  always_comb begin
    rs1_haz = rs1_used && rs1_addr != '0 &&
              (pending[rs1_addr] > CNT_W'(dec_vec[rs1_addr]));
    rs2_haz = rs2_used && rs2_addr != '0 &&
              (pending[rs2_addr] > CNT_W'(dec_vec[rs2_addr]));
    hazard  = rst_n && (rs1_haz || rs2_haz);
    sb_full = rst_n && issue_rd != '0 && pending[issue_rd] == PMAX && !dec_vec[issue_rd];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the array is reset explicitly because reads after reset must return 0;
      // this costs a reset path on every flop, which a plain RAM would not need.
      for (int r = 0; r < NREG; r++) begin
        regs[r]    <= '0;
        pending[r] <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      if (wb_we && wb_rd != '0) regs[wb_rd] <= wb_data;
      for (int r = 1; r < NREG; r++) begin
        if (flush) begin
          pending[r] <= '0;
        end else if (inc_vec[r] && !dec_vec[r]) begin
          if (pending[r] == PMAX) sb_err <= 1'b1;
          else                    pending[r] <= pending[r] + CNT_W'(1);
        end else if (dec_vec[r] && !inc_vec[r]) begin
          // Underflow means a writeback arrived with nothing in flight.
          if (pending[r] == '0) sb_err <= 1'b1;
          else                  pending[r] <= pending[r] - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios followed by random
// traffic, all compared against an array/integer reference model.
module tb_regfile_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int CNT_W = 2;
  localparam int AW    = 5;
  localparam int PMAX  = (1 << CNT_W) - 1;

  logic            clk;
  logic            rst_n;
  logic            wb_we;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_used;
  logic            rs2_used;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            issue_we;
  logic            hazard;
  logic            sb_full;
  logic            flush;
  logic            sb_err;

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_we(issue_we),
    .hazard(hazard), .sb_full(sb_full), .flush(flush), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural values, in-flight write counts, sticky error.
  logic [XLEN-1:0] m_regs [NREG];
  int              m_pend [NREG];
  bit              m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 0;
    end
    m_err = 1'b0;
  endfunction

  function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a);
    if (!rst_n || a == 0) return '0;
    if (wb_we && wb_rd == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic bit exp_src_haz(input bit used, input logic [AW-1:0] a);
    int eff;
    if (!rst_n || !used || a == 0) return 1'b0;
    eff = m_pend[a] - ((wb_we && wb_rd == a) ? 1 : 0);
    return eff > 0;
  endfunction

  function automatic bit exp_full();
    if (!rst_n || issue_rd == 0) return 1'b0;
    return m_pend[issue_rd] == PMAX && !(wb_we && wb_rd == issue_rd);
  endfunction

  // Applies the clock-edge rules to the model using the inputs present at the edge.
  function automatic void model_edge();
    int i;
    int d;
    if (!rst_n) begin
      model_clear();
      return;
    end
    if (wb_we && wb_rd != 0) m_regs[wb_rd] = wb_data;
    if (flush) begin
      for (int r = 0; r < NREG; r++) m_pend[r] = 0;
      return;
    end
    i = (issue_valid && issue_we) ? int'(issue_rd) : 0;
    d = wb_we ? int'(wb_rd) : 0;
    if (i != d) begin
      if (i != 0) begin
        if (m_pend[i] == PMAX) m_err = 1'b1;
        else                   m_pend[i]++;
      end
      if (d != 0) begin
        if (m_pend[d] == 0) m_err = 1'b1;
        else                m_pend[d]--;
      end
    end
  endfunction

  // Check all outputs against the model for the current inputs, then take one edge.
  task automatic cycle();
    #2;
    check("rs1_data", rs1_data, exp_read(rs1_addr));
    check("rs2_data", rs2_data, exp_read(rs2_addr));
    check("hazard",   hazard,   exp_src_haz(rs1_used, rs1_addr) || exp_src_haz(rs2_used, rs2_addr));
    check("sb_full",  sb_full,  exp_full());
    check("sb_err",   sb_err,   m_err);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    wb_we = 0; wb_rd = '0; wb_data = '0;
    rs1_addr = '0; rs2_addr = '0; rs1_used = 0; rs2_used = 0;
    issue_valid = 0; issue_rd = '0; issue_we = 0; flush = 0;
  endtask

  // Two reset edges; the second carries write/issue traffic that reset must override.
  task automatic do_reset();
    set_idle();
    rst_n = 0;
    @(posedge clk);
    model_clear();
    #1;
    wb_we = 1; wb_rd = 5'd5; wb_data = 32'hA5A5_A5A5;
    rs1_addr = 5'd5; rs1_used = 1;
    issue_valid = 1; issue_we = 1; issue_rd = 5'd5;
    cycle();
    rst_n = 1;
    set_idle();
  endtask

  initial begin
    rst_n = 0;
    set_idle();
    do_reset();

    // Every address reads 0 after reset.
    rs1_used = 1; rs2_used = 1;
    for (int a = 0; a < NREG; a++) begin
      rs1_addr = AW'(a);
      rs2_addr = AW'(NREG - 1 - a);
      cycle();
    end
    set_idle();

    // RAW hazard on r5 held for three cycles, released by the bypassed writeback.
    issue_valid = 1; issue_we = 1; issue_rd = 5'd5;
    rs1_addr = 5'd5; rs1_used = 1;
    cycle();
    issue_valid = 0; issue_we = 0;
    repeat (3) begin
      #1 check("raw_hold", hazard, 1);
      cycle();
    end
    wb_we = 1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
    #1;
    check("bypass_r5", rs1_data, 32'hDEAD_BEEF);
    check("release_r5", hazard, 0);
    cycle();
    wb_we = 0;
    #1 check("array_r5", rs1_data, 32'hDEAD_BEEF);
    cycle();

    // Register 0 ignores writes and issues.
    wb_we = 1; wb_rd = '0; wb_data = 32'h1234;
    issue_valid = 1; issue_we = 1; issue_rd = '0;
    rs1_addr = '0; rs1_used = 1;
    #1;
    check("r0_bypass", rs1_data, 0);
    check("r0_full", sb_full, 0);
    cycle();
    set_idle();
    rs1_addr = '0; rs1_used = 1;
    #1 check("r0_hazard", hazard, 0);
    cycle();

    // Saturate r7, overflow it, then a balanced issue+writeback.
    set_idle();
    issue_valid = 1; issue_we = 1; issue_rd = 5'd7;
    repeat (3) cycle();
    issue_valid = 0;
    #1 check("full_r7", sb_full, 1);
    cycle();
    issue_valid = 1;
    cycle();
    issue_valid = 0;
    #1 check("overflow_err", sb_err, 1);
    check("hold_full_r7", sb_full, 1);
    cycle();
    issue_valid = 1; wb_we = 1; wb_rd = 5'd7; wb_data = 32'h7777_0007;
    #1 check("full_release", sb_full, 0);
    cycle();
    set_idle();
    issue_rd = 5'd7;
    #1 check("balanced_r7", sb_full, 1);
    cycle();

    // Flush clears pending; a coincident writeback still lands.
    do_reset();
    issue_valid = 1; issue_we = 1; issue_rd = 5'd3;
    cycle();
    issue_rd = 5'd9;
    cycle();
    set_idle();
    flush = 1; wb_we = 1; wb_rd = 5'd3; wb_data = 32'h55;
    cycle();
    set_idle();
    rs1_addr = 5'd3; rs1_used = 1; rs2_addr = 5'd9; rs2_used = 1;
    #1;
    check("flush_hazard", hazard, 0);
    check("flush_r3", rs1_data, 32'h55);
    check("flush_err", sb_err, 0);
    cycle();

    // Writeback with nothing pending sets a sticky error cleared only by reset.
    set_idle();
    wb_we = 1; wb_rd = 5'd12; wb_data = 32'hC0FF_EE12;
    cycle();
    set_idle();
    rs1_addr = 5'd12;
    repeat (10) cycle();
    #1;
    check("sticky_err", sb_err, 1);
    check("r12_data", rs1_data, 32'hC0FF_EE12);
    do_reset();
    #1 check("err_cleared", sb_err, 0);

    // Random traffic over a small register window to force collisions.
    for (int n = 0; n < 3000; n++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      wb_we       = ($urandom_range(0, 2) == 0);
      wb_rd       = AW'($urandom_range(0, 7));
      wb_data     = $urandom;
      rs1_addr    = AW'($urandom_range(0, 7));
      rs2_addr    = AW'($urandom_range(0, 7));
      rs1_used    = $urandom_range(0, 1) == 1;
      rs2_used    = $urandom_range(0, 1) == 1;
      issue_valid = $urandom_range(0, 1) == 1;
      issue_we    = $urandom_range(0, 3) != 0;
      issue_rd    = AW'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 39) == 0);
      cycle();
    end
    rst_n = 1;
    set_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
